// File: rtl/mux_sweep_checker.sv
// mux_sweep_checker
// Sequential driver/checker wrapped around a switch-level 2:1 MUX (y = s ? b : a).
// Steps the MUX through all 8 {s,a,b} combinations. Each vector is held for
// SETTLE_CYCLES cycles so the transistor-level delays can settle, and then y_in
// is sampled for one cycle. The sampled value is compared with the ideal
// function, and a per-vector fail mask plus an error count are reported.
// Optional build macro: MUX_SWEEP_STOP_ON_FAIL_EN. When it is defined, the sweep
// ends on the first mismatching vector instead of applying all 8.

module mux_sweep_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       s_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Ideal MUX output for vector index {s,a,b} = 7..0, packed as bit i = expected y for vector i.
  localparam logic [7:0]       EXPECTED_Y = 8'hAC;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [2:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       err_q, err_next;
  logic [7:0]       fail_q, fail_next;
  logic             pass_q, pass_next;

  logic             mismatch;
  logic [3:0]       err_sampled;
  logic [7:0]       fail_sampled;
  logic             stop_sweep;
  logic             driving;

  // State and result registers; reset aborts any sweep in progress without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 3'd0;
      cnt    <= '0;
      err_q  <= 4'd0;
      fail_q <= 8'd0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      cnt    <= cnt_next;
      err_q  <= err_next;
      fail_q <= fail_next;
      pass_q <= pass_next;
    end
  end

  // Compare logic for the current vector, only consumed in SAMPLE, so glitches elsewhere are harmless.
  always_comb begin
    mismatch     = (y_in != EXPECTED_Y[idx]);
    err_sampled  = err_q + {3'd0, mismatch};
    fail_sampled = fail_q | (8'(mismatch) << idx);
`ifdef MUX_SWEEP_STOP_ON_FAIL_EN
    stop_sweep   = (idx == 3'd7) || mismatch;
`else
    stop_sweep   = (idx == 3'd7);
`endif
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    err_next   = err_q;
    fail_next  = fail_q;
    pass_next  = pass_q;

    case (state)
      IDLE: begin
        if (start) begin
          idx_next   = 3'd0;
          cnt_next   = '0;
          err_next   = 4'd0;
          fail_next  = 8'd0;
          pass_next  = 1'b0;
          state_next = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      SAMPLE: begin
        err_next  = err_sampled;
        fail_next = fail_sampled;
        if (stop_sweep) begin
          pass_next  = (err_sampled == 4'd0);
          state_next = DONE;
        end else begin
          idx_next   = idx + 3'd1;
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The MUX inputs are driven only while a vector is active; at all other times they are parked at 0.
  always_comb begin
    driving   = (state == SETTLE) || (state == SAMPLE);
    busy      = driving;
    done      = (state == DONE);
    s_out     = driving & idx[2];
    a_out     = driving & idx[1];
    b_out     = driving & idx[0];
    pass      = pass_q;
    err_count = err_q;
    fail_vec  = fail_q;
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// tb_mux_sweep_checker
// Randomised self-checking bench. Two checker instances are used: the default
// SETTLE_CYCLES=4 and SETTLE_CYCLES=1. Each instance is fed by a behavioural MUX
// whose output glitches whenever its inputs change, then settles 3 ns later.
// The settled value can optionally be faulted per vector, tied to 0 or inverted.

module tb_mux_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic       y0 = 1'b0, y1 = 1'b0;
  logic       a0, b0, s0, busy0, done0, pass0;
  logic       a1, b1, s1, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] fail0, fail1;

  int         mode0 = 0, mode1 = 0;
  logic [7:0] mask0 = 8'h00, mask1 = 8'h00;

  int         sel = 0;
  logic       obs_a, obs_b, obs_s, obs_busy, obs_done, obs_pass;
  logic [3:0] obs_err;
  logic [7:0] obs_fail;

  int vec_count   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start0), .y_in(y0),
    .a_out(a0), .b_out(b0), .s_out(s0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_vec(fail0)
  );

  mux_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_fast (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1),
    .a_out(a1), .b_out(b1), .s_out(s1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    obs_a    = (sel != 0) ? a1    : a0;
    obs_b    = (sel != 0) ? b1    : b0;
    obs_s    = (sel != 0) ? s1    : s0;
    obs_busy = (sel != 0) ? busy1 : busy0;
    obs_done = (sel != 0) ? done1 : done0;
    obs_pass = (sel != 0) ? pass1 : pass0;
    obs_err  = (sel != 0) ? err1  : err0;
    obs_fail = (sel != 0) ? fail1 : fail0;
  end

  // Behavioural MUX output seen by the checker: mode 0 = ideal with per-vector fault mask, 1 = tied 0, 2 = inverted.
  function automatic logic model_y(input int mode, input logic [7:0] mask,
                                   input logic s, input logic a, input logic b);
    logic ideal;
    logic [2:0] v;
    ideal = s ? b : a;
    v = {s, a, b};
    case (mode)
      1:       model_y = 1'b0;
      2:       model_y = ~ideal;
      default: model_y = ideal ^ mask[v];
    endcase
  endfunction

  // Glitch on every input change, then settle after the transistor-level delay.
  always @(s0, a0, b0, mode0, mask0) begin
    y0 = ~y0;
    #3;
    y0 = model_y(mode0, mask0, s0, a0, b0);
  end

  always @(s1, a1, b1, mode1, mask1) begin
    y1 = ~y1;
    #3;
    y1 = model_y(mode1, mask1, s1, a1, b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int which, input logic v);
    if (which != 0) start1 = v;
    else            start0 = v;
  endtask

  // Run one full sweep on the chosen instance and check vectors, timing and results against the model.
  task automatic applyStimulus(input int which, input int mode, input logic [7:0] mask, input bit repulse);
    int         per;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_fail;
    bit         got_done;
    bit         stopped;
    logic [2:0] v;
    logic       y, ideal;

    per      = (which != 0) ? 2 : 5;
    exp_err  = 0;
    exp_fail = 8'h00;
    exp_done = 8 * per + 1;
    stopped  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!stopped) begin
        v = 3'(i);
        ideal = v[2] ? v[0] : v[1];
        y = model_y(mode, mask, v[2], v[1], v[0]);
        if (y != ideal) begin
          exp_err++;
          exp_fail[i] = 1'b1;
`ifdef MUX_SWEEP_STOP_ON_FAIL_EN
          stopped  = 1'b1;
          exp_done = (i + 1) * per + 1;
`endif
        end
      end
    end

    sel = which;
    if (which != 0) begin mode1 = mode; mask1 = mask; end
    else            begin mode0 = mode; mask0 = mask; end
    repeat (2) @(negedge clk);

    setStart(which, 1'b1);
    got_done = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) setStart(which, 1'b0);
      if (repulse && c == 5 * per + 2) setStart(which, 1'b1);
      if (repulse && c == 5 * per + 3) setStart(which, 1'b0);
      if (obs_done) begin
        checkOutput("done_cycle", c, exp_done);
        checkOutput("busy_in_done", obs_busy, 1'b0);
        checkOutput("pass", obs_pass, (exp_err == 0));
        checkOutput("err_count", obs_err, exp_err);
        checkOutput("fail_vec", obs_fail, exp_fail);
        checkOutput("abs_in_done", {obs_s, obs_a, obs_b}, 3'd0);
        got_done = 1'b1;
        break;
      end else if (c < exp_done) begin
        checkOutput("vector", {obs_s, obs_a, obs_b}, (c - 1) / per);
        checkOutput("busy", obs_busy, 1'b1);
      end
    end
    if (!got_done) checkOutput("done_timeout", 1'b0, 1'b1);

    @(negedge clk);
    checkOutput("done_one_cycle", obs_done, 1'b0);
    checkOutput("idle_busy", obs_busy, 1'b0);
    checkOutput("pass_held", obs_pass, (exp_err == 0));
    checkOutput("err_held", obs_err, exp_err);
    checkOutput("fail_held", obs_fail, exp_fail);
  endtask

  // Abort a sweep with an asynchronous reset during vector 3, then confirm a clean restart.
  task automatic resetMidSweep();
    int seen_done;
    sel = 0;
    mode0 = 0;
    mask0 = 8'h00;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
    end
    checkOutput("pre_reset_vector", {s0, a0, b0}, 3'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_abs", {s0, a0, b0}, 3'd0);
    checkOutput("rst_busy", busy0, 1'b0);
    checkOutput("rst_done", done0, 1'b0);
    checkOutput("rst_pass", pass0, 1'b0);
    checkOutput("rst_err", err0, 4'd0);
    checkOutput("rst_fail", fail0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done0) seen_done++;
    end
    checkOutput("no_done_after_reset", seen_done, 0);
    applyStimulus(0, 0, 8'h00, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    #1;
    checkOutput("reset_abs", {s0, a0, b0}, 3'd0);
    checkOutput("reset_busy", busy0, 1'b0);
    checkOutput("reset_done", done0, 1'b0);
    checkOutput("reset_pass", pass0, 1'b0);
    checkOutput("reset_err", err0, 4'd0);
    checkOutput("reset_fail", fail0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 8'h00, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b0);
    applyStimulus(0, 2, 8'h00, 1'b0);
    applyStimulus(0, 0, 8'h00, 1'b1);
    applyStimulus(1, 0, 8'h00, 1'b0);
    applyStimulus(1, 1, 8'h00, 1'b0);
    resetMidSweep();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), 0, 8'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sweep_checker.md
Name: mux_sweep_checker

Overview:
- Sequential test-driver stage wrapped around the switch-level 2:1 MUX (`y = s ? b : a`).
- Upstream role: drives `a_out`/`b_out`/`s_out` into the MUX's `a`/`b`/`s` inputs.
- Downstream role: samples the MUX output `y` after a programmable settle time, since the transistor-level delays span several ns.
- Sweeps all 8 input combinations, compares each against the ideal function and reports per-vector pass/fail plus a total error count.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each vector is held before `y_in` is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock; bench period 10 ns.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- y_in  input  1  MUX output `y`.
- a_out  output  1  drives MUX `a`.
- b_out  output  1  drives MUX `b`.
- s_out  output  1  drives MUX `s`.
- busy  output  1  high from the start edge until DONE is entered.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  1 when err_count==0; valid from done, held until the next start.
- err_count  output  4  number of mismatching vectors, 0..8.
- fail_vec  output  8  bit i set when vector i mismatched.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high. While rst=1, all outputs are 0, state=IDLE, idx=0, cnt=0. Reset mid-sweep aborts immediately with no done pulse.
- Vector encoding: idx[2:0] = {s,a,b}, so `s_out=idx[2]`, `a_out=idx[1]`, `b_out=idx[0]`.
- Expected y per idx 0..7: 0,0,1,1,0,1,0,1.
- State IDLE:
  - start=1 at the edge → idx=0; drive vector 0; cnt=0; clear err_count and fail_vec; busy=1; go to SETTLE.
  - Otherwise a/b/s outputs stay 0.
- State SETTLE:
  - Vector held; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 → SAMPLE.
- State SAMPLE (one cycle): at its closing edge, compare `y_in` with expected[idx].
  - On mismatch: set fail_vec[idx] and increment err_count.
  - If idx==7: go to DONE and drive a/b/s to 0.
  - Else: idx+1, drive the new vector, cnt=0, go to SETTLE.
- State DONE (one cycle): done=1, busy=0, pass=(err_count==0); then → IDLE.
- Per-vector cost: SETTLE_CYCLES+1 cycles.
- Sweep timing: done is high in cycle 8*(SETTLE_CYCLES+1)+1 after the start edge; with the default, cycle 41.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new sweep begins on the first IDLE cycle.
- `y_in` is sampled only in SAMPLE. Glitches during SETTLE have no effect.
- err_count saturates naturally at 8; no wrap is possible.
- Between sweeps, pass/err_count/fail_vec keep their last values until the next start edge clears them.

Optional Feature:
- Macro: MUX_SWEEP_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in SAMPLE, go straight to DONE and drive a/b/s to 0.
  - fail_vec then has exactly that one bit set and err_count=1.
  - done pulses at (idx+1)*(SETTLE_CYCLES+1)+1 cycles after start.
- Undefined: all 8 vectors are always applied (baseline behaviour above).

Test Plan:
- Correct switch-level MUX connected, SETTLE_CYCLES=4, pulse start → done in cycle 41, pass=1, err_count=0, fail_vec=8'h00; `s_out`/`a_out`/`b_out` step through 000..111, each held 5 cycles.
- `y_in` tied 0 → pass=0, err_count=4, fail_vec=8'hAC.
- `y_in` driven as the inverted ideal output → err_count=8, fail_vec=8'hFF.
- rst pulsed during vector 3 → all outputs 0 asynchronously, no done pulse; a new start gives a clean sweep with pass=1.
- start re-pulsed during vector 5 → ignored; single done at cycle 41. SETTLE_CYCLES=1 with a correct MUX → done in cycle 17, pass=1.
- MUX_SWEEP_STOP_ON_FAIL_EN defined, `y_in` tied 0 → done at cycle 16, fail_vec=8'h04, err_count=1, pass=0.
